// File: rtl/sa_row_collector.sv
// Output de-skew for the systolic array: re-aligns staircased result lanes into
// full rows, buffers them in a FIFO and stalls the array while the buffer is full.
module sa_row_collector #(
    parameter int LANES      = 4,
    parameter int DAT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [LANES-1:0]                      i_lane_vld,
    input  logic [LANES*DAT_WIDTH-1:0]            i_lane_dat,
    output logic                                  o_en,
    output logic                                  o_row_vld,
    output logic [LANES*DAT_WIDTH-1:0]            o_row_dat,
    input  logic                                  i_row_rdy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       o_level,
    output logic                                  o_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH+1);
    localparam int ROW_W = LANES*DAT_WIDTH;

    logic [LANES-1:0] al_vld;
    logic [ROW_W-1:0] al_dat;

    // Lane k is delayed LANES-1-k enabled cycles; bit 0 of each shift register is the newest entry.
    for (genvar k = 0; k < LANES-1; k++) begin : g_lane
        localparam int DEPTH = LANES-1-k;

        logic [DEPTH-1:0]                vld_sr;
        logic [DEPTH-1:0][DAT_WIDTH-1:0] dat_sr;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_sr <= '0;
            end else if (o_en) begin
                vld_sr <= DEPTH'({vld_sr, i_lane_vld[k]});
            end
        end

        always_ff @(posedge clk) begin
            if (o_en) begin
                dat_sr <= (DEPTH*DAT_WIDTH)'({dat_sr, i_lane_dat[k*DAT_WIDTH +: DAT_WIDTH]});
            end
        end

        assign al_vld[k]                          = vld_sr[DEPTH-1];
        assign al_dat[k*DAT_WIDTH +: DAT_WIDTH]   = dat_sr[DEPTH-1];
    end

    assign al_vld[LANES-1]                                  = i_lane_vld[LANES-1];
    assign al_dat[(LANES-1)*DAT_WIDTH +: DAT_WIDTH]         = i_lane_dat[(LANES-1)*DAT_WIDTH +: DAT_WIDTH];

    logic [ROW_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             err;
    logic             push;
    logic             pop;
    logic             partial;

    always_comb begin
        o_en    = (level != LVL_W'(FIFO_DEPTH));
        push    = o_en && (&al_vld);
        partial = o_en && (|al_vld) && !(&al_vld);
        pop     = (level != '0) && i_row_rdy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
            if (partial) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= al_dat;
        end
    end

    assign o_row_vld = (level != '0);
    assign o_row_dat = mem[rd_ptr];
    assign o_level   = level;
    assign o_err     = err;

endmodule

// File: tb/tb_sa_row_collector.sv
// Bench for sa_row_collector: per-cycle vector table, directed corner sequences and
// random traffic checked against a row-level queue model of the collector.
module tb_sa_row_collector;

    localparam int LANES = 4;
    localparam int W     = 16;
    localparam int DEPTH = 8;
    localparam int ROW_W = LANES*W;
    localparam int NSLOT = 8192;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic [LANES-1:0]              i_lane_vld = '0;
    logic [ROW_W-1:0]              i_lane_dat = '0;
    logic                          o_en;
    logic                          o_row_vld;
    logic [ROW_W-1:0]              o_row_dat;
    logic                          i_row_rdy = 1'b0;
    logic [$clog2(DEPTH+1)-1:0]    o_level;
    logic                          o_err;

    sa_row_collector #(.LANES(LANES), .DAT_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_lane_vld (i_lane_vld),
        .i_lane_dat (i_lane_dat),
        .o_en       (o_en),
        .o_row_vld  (o_row_vld),
        .o_row_dat  (o_row_dat),
        .i_row_rdy  (i_row_rdy),
        .o_level    (o_level),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANES-1:0] mask;
        logic [ROW_W-1:0] dat;
    } row_t;

    typedef struct {
        bit rst;
        bit rdy;
        int load;
        bit chk;
        int lvl;
        bit en;
        bit vld;
        bit err;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Rows waiting to start, and rows by the enabled-cycle index at which lane 0 was presented
    row_t             send_q[$];
    logic [LANES-1:0] slot_mask [NSLOT];
    logic [ROW_W-1:0] slot_dat  [NSLOT];
    int               n = LANES;
    int               row_no = 1;

    logic [ROW_W-1:0] mq[$];
    bit               merr = 1'b0;
    bit               model_ok = 1'b0;

    vec_t tbl[33];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [ROW_W-1:0] rand_row();
        logic [ROW_W-1:0] d;
        for (int k = 0; k < LANES; k++) d[k*W +: W] = W'($urandom);
        return d;
    endfunction

    function automatic void push_row(input int drop);
        row_t r;
        r.mask = '1;
        if (drop >= 0) r.mask[drop] = 1'b0;
        for (int k = 0; k < LANES; k++) r.dat[k*W +: W] = W'(row_no*16 + k);
        row_no++;
        send_q.push_back(r);
    endfunction

    // One clock: check outputs against the model, drive inputs, advance model, move to next negedge
    task automatic step(input bit r, input bit rdy);
        logic [LANES-1:0] v;
        logic [ROW_W-1:0] d;
        bit               en_m;
        bit               do_pop;
        int               s;
        if (model_ok) begin
            chk("m_en",    o_en,      64'(mq.size() != DEPTH));
            chk("m_level", o_level,   64'(mq.size()));
            chk("m_vld",   o_row_vld, 64'(mq.size() != 0));
            chk("m_err",   o_err,     64'(merr));
            if (mq.size() != 0) chk("m_dat", o_row_dat, mq[0]);
        end
        en_m      = (mq.size() != DEPTH);
        rst       = r;
        i_row_rdy = rdy;
        v         = '0;
        d         = rand_row();
        if (r) begin
            mq.delete();
            merr = 1'b0;
            for (int j = n-LANES; j < n; j++) slot_mask[j] = '0;
            model_ok = 1'b1;
        end else begin
            do_pop = (mq.size() != 0) && rdy;
            if (en_m) begin
                if (send_q.size() != 0) begin
                    slot_mask[n] = send_q[0].mask;
                    slot_dat[n]  = send_q[0].dat;
                    void'(send_q.pop_front());
                end else begin
                    slot_mask[n] = '0;
                    slot_dat[n]  = rand_row();
                end
                for (int k = 0; k < LANES; k++) begin
                    v[k]         = slot_mask[n-k][k];
                    d[k*W +: W]  = slot_dat[n-k][k*W +: W];
                end
                s = n - (LANES-1);
                if (do_pop) void'(mq.pop_front());
                if (&slot_mask[s]) mq.push_back(slot_dat[s]);
                else if (|slot_mask[s]) merr = 1'b1;
                n++;
            end else begin
                v = LANES'($urandom);
                if (do_pop) void'(mq.pop_front());
            end
        end
        i_lane_vld = v;
        i_lane_dat = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int c;
        bit rdy;
        for (int j = 0; j < NSLOT; j++) begin
            slot_mask[j] = '0;
            slot_dat[j]  = '0;
        end

        // Reset, single row, then 12 rows against a stalled consumer and a drain across the full point
        for (int i = 0; i < 33; i++)
            tbl[i] = '{rst:1'b0, rdy:1'b1, load:0, chk:1'b1, lvl:0, en:1'b1, vld:1'b0, err:1'b0};
        tbl[0].rst = 1'b1; tbl[0].chk = 1'b0;
        tbl[1].load = 1;
        tbl[5].lvl = 1; tbl[5].vld = 1'b1;
        tbl[6].load = 12;
        for (int i = 6; i <= 19; i++) tbl[i].rdy = 1'b0;
        for (int i = 10; i <= 16; i++) begin tbl[i].lvl = i-9; tbl[i].vld = 1'b1; end
        for (int i = 17; i <= 20; i++) begin tbl[i].lvl = 8; tbl[i].en = 1'b0; tbl[i].vld = 1'b1; end
        for (int i = 21; i <= 25; i++) begin tbl[i].lvl = 7; tbl[i].vld = 1'b1; end
        for (int i = 26; i <= 31; i++) begin tbl[i].lvl = 32-i; tbl[i].vld = 1'b1; end

        @(negedge clk);
        for (int i = 0; i < 33; i++) begin
            if (tbl[i].chk) begin
                chk("t_level", o_level,   64'(tbl[i].lvl));
                chk("t_en",    o_en,      64'(tbl[i].en));
                chk("t_vld",   o_row_vld, 64'(tbl[i].vld));
                chk("t_err",   o_err,     64'(tbl[i].err));
            end
            if (i == 5) chk("t_single_dat", o_row_dat, 64'h0013_0012_0011_0010);
            for (int j = 0; j < tbl[i].load; j++) push_row(-1);
            step(tbl[i].rst, tbl[i].rdy);
        end

        // Streaming: 20 rows back to back with a ready consumer
        for (int j = 0; j < 20; j++) push_row(-1);
        for (int j = 0; j < 26; j++) begin
            chk("stream_en", o_en, 1);
            chk("stream_lvl_le1", 64'(o_level <= 1), 1);
            step(1'b0, 1'b1);
        end
        chk("stream_empty", o_row_vld, 0);

        // Misalignment: lane 2 missing on one row, good rows after it
        push_row(2);
        for (int j = 0; j < 3; j++) push_row(-1);
        for (int j = 0; j < 12; j++) step(1'b0, 1'b1);
        chk("err_sticky", o_err, 1);

        // Reset with buffered rows and rows still in the de-skew stages
        for (int j = 0; j < 10; j++) push_row(-1);
        c = 0;
        while (mq.size() != 5 && c < 40) begin
            step(1'b0, 1'b0);
            c++;
        end
        chk("pre_rst_level", o_level, 5);
        step(1'b1, 1'b0);
        chk("rst_level", o_level, 0);
        chk("rst_vld", o_row_vld, 0);
        chk("rst_en", o_en, 1);
        chk("rst_err", o_err, 0);
        for (int j = 0; j < 15; j++) step(1'b0, 1'b1);

        // Random traffic with bursts of backpressure and rare resets
        for (int i = 0; i < 2000; i++) begin
            if (send_q.size() < 3 && $urandom_range(0, 1) == 1)
                push_row(($urandom_range(0, 15) == 0) ? int'($urandom_range(0, LANES-1)) : -1);
            if ((i / 150) % 2 == 1) rdy = ($urandom_range(0, 4) == 0);
            else rdy = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 399) == 0, rdy);
        end
        for (int j = 0; j < 30; j++) step(1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
